// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional performance counters are compiled in with `define MIPS_CTRL_PERF_CNT_EN.
//
// state   | meaning
// FETCH   | read instruction at PC, PC += 4 when memory completes (or halt on PC == 0)
// DECODE  | precompute branch target into ALUOut, drop unsupported instructions
// EXEC    | ALU op / address calc / branch compare / jump
// MEM     | data memory read or write, held while waitrequest is high
// WB      | register-file write
// HALTED  | core stopped; only reset leaves
module mips_multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             waitrequest,
  input  logic             pc_zero,
  output logic             active,
  output logic [2:0]       state,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             branch_ne,
  output logic [1:0]       PCSource,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic is_rtype, r_alu, r_jr;
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_imm, supported;

  assign is_rtype = (opcode == 6'b000000);
  assign r_alu    = (funct == 6'b100001) || (funct == 6'b100011) || (funct == 6'b100100) ||
                    (funct == 6'b100101) || (funct == 6'b100110) || (funct == 6'b101010);
  assign r_jr     = (funct == 6'b001000);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_bne   = (opcode == 6'b000101);
  assign is_j     = (opcode == 6'b000010);
  assign is_imm   = (opcode == 6'b001001) || (opcode == 6'b001100) ||
                    (opcode == 6'b001101) || (opcode == 6'b001110);
  assign supported = (is_rtype && (r_alu || r_jr)) || is_lw || is_sw || is_beq ||
                     is_bne || is_j || is_imm;

  always_ff @(posedge clk) begin
    if (reset) state_q <= state_e'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    active      = 1'b1;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    branch_ne   = 1'b0;
    PCSource    = 2'd0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;

    case (state_q)
      FETCH: begin
        if (pc_zero) begin
          state_d = HALTED;
        end else begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          if (!waitrequest) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        state_d = supported ? EXEC : FETCH;
      end
      EXEC: begin
        state_d = FETCH;
        if (is_rtype && r_jr) begin
          PCWrite  = 1'b1;
          PCSource = 2'd3;
        end else if (is_rtype) begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = WB;
        end else if (is_lw || is_sw) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
          state_d = MEM;
        end else if (is_imm) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
          ALUOp   = 2'b11;
          state_d = WB;
        end else if (is_beq || is_bne) begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'd1;
          branch_ne   = is_bne;
        end else if (is_j) begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
        end
      end
      MEM: begin
        IorD     = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (!waitrequest) state_d = is_lw ? WB : FETCH;
      end
      WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype;
        MemtoReg = is_lw;
        state_d  = FETCH;
      end
      HALTED: begin
        active = 1'b0;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset wins over everything so strobes never leak during a mid-access reset.
    if (reset) begin
      active      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      ALUOp       = 2'd0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      branch_ne   = 1'b0;
      PCSource    = 2'd0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
    end
  end

  assign state = reset ? 3'd0 : state_q;

`ifdef MIPS_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (active) cycle_count <= cycle_count + 1'b1;
      if (state_q == FETCH && !pc_zero && !waitrequest) instr_count <= instr_count + 1'b1;
    end
  end
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl; expected control words are hand-built
// from the per-state output tables.
module tb_mips_multicycle_ctrl;

  logic        clk, reset, waitrequest, pc_zero;
  logic [5:0]  opcode, funct;
  logic        active, ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic        branch_ne, RegWrite, RegDst, MemtoReg;
  logic [2:0]  state;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] cycle_count, instr_count;
  logic [31:0] ctl;

  int ncomp = 0;
  int nfail = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .waitrequest(waitrequest),
    .pc_zero(pc_zero), .active(active), .state(state), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .branch_ne(branch_ne), .PCSource(PCSource),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  assign ctl = {14'b0, active, ALUSrcA, ALUSrcB, ALUOp, IorD, MemRead, MemWrite, IRWrite,
                PCWrite, PCWriteCond, branch_ne, PCSource, RegWrite, RegDst, MemtoReg};

  localparam int ACT  = 1 << 17;
  localparam int SRCA = 1 << 16;
  localparam int IORD = 1 << 11;
  localparam int MRD  = 1 << 10;
  localparam int MWR  = 1 << 9;
  localparam int IRW  = 1 << 8;
  localparam int PCW  = 1 << 7;
  localparam int PCWC = 1 << 6;
  localparam int BNE  = 1 << 5;
  localparam int RW   = 1 << 2;
  localparam int RDST = 1 << 1;
  localparam int M2R  = 1 << 0;

  function automatic int srcb(int v); return v << 14; endfunction
  function automatic int aop(int v);  return v << 12; endfunction
  function automatic int pcs(int v);  return v << 3;  endfunction

  localparam int C_F     = ACT | MRD | (1 << 14) | IRW | PCW;
  localparam int C_FST   = ACT | MRD | (1 << 14);
  localparam int C_D     = ACT | (3 << 14);
  localparam int C_EXR   = ACT | SRCA | (2 << 12);
  localparam int C_WBR   = ACT | RW | RDST;
  localparam int C_EXLS  = ACT | SRCA | (2 << 14);
  localparam int C_MEMLW = ACT | IORD | MRD;
  localparam int C_MEMSW = ACT | IORD | MWR;
  localparam int C_WBLW  = ACT | RW | M2R;
  localparam int C_WBI   = ACT | RW;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check state and control word for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input int st, input int c);
    #1;
    chk({tag, "_state"}, {29'b0, state}, st);
    chk({tag, "_ctl"}, ctl, c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int cy, input int ins);
`ifdef MIPS_CTRL_PERF_CNT_EN
    chk({tag, "_cycles"}, cycle_count, cy);
    chk({tag, "_instrs"}, instr_count, ins);
`else
    chk({tag, "_cycles"}, cycle_count, 0);
    chk({tag, "_instrs"}, instr_count, 0);
    if (cy < 0 || ins < 0) $display("negative count request");
`endif
  endtask

  initial begin
    reset = 1'b1; waitrequest = 1'b0; pc_zero = 1'b0; opcode = 6'h00; funct = 6'h21;
    @(posedge clk); #1;
    chk("reset_ctl", ctl, 0);
    chk("reset_state", {29'b0, state}, 0);
    waitrequest = 1'b1;
    #1 chk("reset_ctl_wr", ctl, 0);
    waitrequest = 1'b0;
    reset = 1'b0;

    // ADDU: 0,1,2,4 -> 4 cycles
    cyc("addu_f", 0, C_F);
    cyc("addu_d", 1, C_D);
    cyc("addu_ex", 2, C_EXR);
    cyc("addu_wb", 4, C_WBR);
    chk_cnt("addu", 4, 1);

    // LW: 2 FETCH stalls, 3 MEM stalls, waitrequest high in DECODE/EXEC/WB is ignored -> 10 cycles
    opcode = 6'h23; funct = 6'h00; waitrequest = 1'b1;
    cyc("lw_fst0", 0, C_FST);
    cyc("lw_fst1", 0, C_FST);
    waitrequest = 1'b0;
    cyc("lw_f", 0, C_F);
    waitrequest = 1'b1;
    cyc("lw_d", 1, C_D);
    cyc("lw_ex", 2, C_EXLS);
    cyc("lw_mst0", 3, C_MEMLW);
    cyc("lw_mst1", 3, C_MEMLW);
    cyc("lw_mst2", 3, C_MEMLW);
    waitrequest = 1'b0;
    cyc("lw_m", 3, C_MEMLW);
    waitrequest = 1'b1;
    cyc("lw_wb", 4, C_WBLW);
    waitrequest = 1'b0;
    chk_cnt("lw", 14, 2);

    // BNE then BEQ: 3 cycles each
    opcode = 6'h05;
    cyc("bne_f", 0, C_F);
    cyc("bne_d", 1, C_D);
    cyc("bne_ex", 2, ACT | SRCA | aop(1) | PCWC | pcs(1) | BNE);
    opcode = 6'h04;
    cyc("beq_f", 0, C_F);
    cyc("beq_d", 1, C_D);
    cyc("beq_ex", 2, ACT | SRCA | aop(1) | PCWC | pcs(1));

    // ORI: 4 cycles
    opcode = 6'h0D;
    cyc("ori_f", 0, C_F);
    cyc("ori_d", 1, C_D);
    cyc("ori_ex", 2, ACT | SRCA | srcb(2) | aop(3));
    cyc("ori_wb", 4, C_WBI);
    chk_cnt("ori", 24, 5);

    // Unsupported opcode and unsupported R-type funct: 2 cycles each
    opcode = 6'h3F;
    cyc("bad_op_f", 0, C_F);
    cyc("bad_op_d", 1, C_D);
    opcode = 6'h00; funct = 6'h00;
    cyc("bad_fn_f", 0, C_F);
    cyc("bad_fn_d", 1, C_D);

    // JR and J: 3 cycles each
    funct = 6'h08;
    cyc("jr_f", 0, C_F);
    cyc("jr_d", 1, C_D);
    cyc("jr_ex", 2, ACT | PCW | pcs(3));
    opcode = 6'h02;
    cyc("j_f", 0, C_F);
    cyc("j_d", 1, C_D);
    cyc("j_ex", 2, ACT | PCW | pcs(2));
    chk_cnt("jumps", 34, 9);

    // SW with a MEM stall, reset mid-access
    opcode = 6'h2B; funct = 6'h00;
    cyc("sw_f", 0, C_F);
    cyc("sw_d", 1, C_D);
    cyc("sw_ex", 2, C_EXLS);
    waitrequest = 1'b1;
    cyc("sw_mst", 3, C_MEMSW);
    chk("sw_mst_hold_state", {29'b0, state}, 3);
    chk("sw_mst_hold_ctl", ctl, C_MEMSW);
    chk_cnt("sw_pre_rst", 38, 10);
    reset = 1'b1;
    #1;
    chk("sw_rst_ctl", ctl, 0);
    chk("sw_rst_state", {29'b0, state}, 0);
    @(posedge clk); #1;
    reset = 1'b0; waitrequest = 1'b0;
    chk_cnt("post_rst", 0, 0);
    #1 chk("post_rst_state", {29'b0, state}, 0);

    // pc_zero in FETCH: no memory access, then HALTED for 20 cycles
    pc_zero = 1'b1;
    cyc("pcz_f", 0, ACT);
    pc_zero = 1'b0;
    for (int i = 0; i < 20; i++) cyc("halted", 5, 0);
    chk_cnt("halted", 1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("after_halt_f", 0, C_F);
    cyc("after_halt_d", 1, C_D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
